// File: rtl/ex_mem_pipe_pkg.sv
// Shared EX/MEM definitions: ALU opcode bus, NOP payload constants, memory-op and size codes.
// Used by the ex_mem_pipe slice (EX_MEM_SKID_EN selects the skid-buffered build of the top).
package ex_mem_pipe_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned RADDR_W_DEF = 5;
    localparam int unsigned ALUOP_W_DEF = 8;

    typedef logic [ALUOP_W_DEF-1:0] AluOpBus;

    localparam AluOpBus                 ALU_NOP_OP = 8'h00;
    localparam logic [RADDR_W_DEF-1:0]  NopRegAddr = '0;
    localparam logic [XLEN_DEF-1:0]     ZeroWord   = '0;
    localparam logic                    Enable     = 1'b1;
    localparam logic                    Disable    = 1'b0;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } mem_size_e;

    // A pending load cannot be forwarded; its data only exists after MEM.
    function automatic logic is_load(input logic [1:0] memop);
        return memop == 2'(MEM_LOAD);
    endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// EX->MEM handshake and payload bundle; the pipe register takes the slave view.
// Signal names keep the _i/_o direction as seen from the pipe register.
interface ex_mem_pipe_if
    import ex_mem_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF,
    parameter int unsigned ALUOP_W = ALUOP_W_DEF
);
    logic               ex_valid_i;
    logic               ex_ready_o;
    logic [ALUOP_W-1:0] aluop_i;
    logic               wreg_i;
    logic [RADDR_W-1:0] waddr_i;
    logic [XLEN-1:0]    alurslt_i;
    logic [1:0]         memop_i;
    logic [1:0]         memsize_i;
    logic [XLEN-1:0]    sdata_i;
    logic               flush_i;

    logic               mem_valid_o;
    logic               mem_ready_i;
    logic [ALUOP_W-1:0] aluop_o;
    logic               wreg_o;
    logic [RADDR_W-1:0] waddr_o;
    logic [XLEN-1:0]    alurslt_o;
    logic [1:0]         memop_o;
    logic [1:0]         memsize_o;
    logic [XLEN-1:0]    sdata_o;
    logic               misalign_o;
    logic               fwd_en_o;
    logic               load_hazard_o;

    modport master (
        output ex_valid_i, aluop_i, wreg_i, waddr_i, alurslt_i, memop_i, memsize_i,
               sdata_i, flush_i, mem_ready_i,
        input  ex_ready_o, mem_valid_o, aluop_o, wreg_o, waddr_o, alurslt_o, memop_o,
               memsize_o, sdata_o, misalign_o, fwd_en_o, load_hazard_o
    );

    modport slave (
        input  ex_valid_i, aluop_i, wreg_i, waddr_i, alurslt_i, memop_i, memsize_i,
               sdata_i, flush_i, mem_ready_i,
        output ex_ready_o, mem_valid_o, aluop_o, wreg_o, waddr_o, alurslt_o, memop_o,
               memsize_o, sdata_o, misalign_o, fwd_en_o, load_hazard_o
    );
endinterface

// File: rtl/ex_mem_pipe_slot.sv
// pipe_slot: one EX/MEM payload entry with load/clear controls, x0 write suppression
// and misaligned-access detection at load time. clear wins over load.
module pipe_slot
    import ex_mem_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF,
    parameter int unsigned ALUOP_W = ALUOP_W_DEF
) (
    input  logic               dclk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [ALUOP_W-1:0] d_aluop,
    input  logic               d_wreg,
    input  logic [RADDR_W-1:0] d_waddr,
    input  logic [XLEN-1:0]    d_alurslt,
    input  logic [1:0]         d_memop,
    input  logic [1:0]         d_memsize,
    input  logic [XLEN-1:0]    d_sdata,
    input  logic               d_misalign,
    output logic               q_valid,
    output logic [ALUOP_W-1:0] q_aluop,
    output logic               q_wreg,
    output logic [RADDR_W-1:0] q_waddr,
    output logic [XLEN-1:0]    q_alurslt,
    output logic [1:0]         q_memop,
    output logic [1:0]         q_memsize,
    output logic [XLEN-1:0]    q_sdata,
    output logic               q_misalign
);

    logic               misalign_hit;
    logic               n_valid;
    logic [ALUOP_W-1:0] n_aluop;
    logic               n_wreg;
    logic [RADDR_W-1:0] n_waddr;
    logic [XLEN-1:0]    n_alurslt;
    logic [1:0]         n_memop;
    logic [1:0]         n_memsize;
    logic [XLEN-1:0]    n_sdata;
    logic               n_misalign;

    // Alignment only matters for real memory accesses; byte accesses never fault.
    always_comb begin
        misalign_hit = Disable;
        if (d_memop != 2'(MEM_NONE)) begin
            case (d_memsize)
                2'(MEM_SIZE_H): misalign_hit = d_alurslt[0];
                2'(MEM_SIZE_W): misalign_hit = |d_alurslt[1:0];
                default:        misalign_hit = Disable;
            endcase
        end
    end

    // Next entry: hold, bubble on clear, or capture (d_misalign carries a flag from an upstream slot).
    always_comb begin
        n_valid    = q_valid;
        n_aluop    = q_aluop;
        n_wreg     = q_wreg;
        n_waddr    = q_waddr;
        n_alurslt  = q_alurslt;
        n_memop    = q_memop;
        n_memsize  = q_memsize;
        n_sdata    = q_sdata;
        n_misalign = q_misalign;
        if (clear) begin
            n_valid    = Disable;
            n_aluop    = ALUOP_W'(ALU_NOP_OP);
            n_wreg     = Disable;
            n_waddr    = RADDR_W'(NopRegAddr);
            n_alurslt  = XLEN'(ZeroWord);
            n_memop    = 2'(MEM_NONE);
            n_memsize  = 2'(MEM_SIZE_B);
            n_sdata    = XLEN'(ZeroWord);
            n_misalign = Disable;
        end else if (load) begin
            n_valid    = Enable;
            n_aluop    = d_aluop;
            n_wreg     = d_wreg & (d_waddr != RADDR_W'(NopRegAddr));
            n_waddr    = d_waddr;
            n_alurslt  = d_alurslt;
            n_memop    = d_memop;
            n_memsize  = d_memsize;
            n_sdata    = d_sdata;
            n_misalign = d_misalign | misalign_hit;
        end
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            q_valid    <= Disable;
            q_aluop    <= ALUOP_W'(ALU_NOP_OP);
            q_wreg     <= Disable;
            q_waddr    <= RADDR_W'(NopRegAddr);
            q_alurslt  <= XLEN'(ZeroWord);
            q_memop    <= 2'(MEM_NONE);
            q_memsize  <= 2'(MEM_SIZE_B);
            q_sdata    <= XLEN'(ZeroWord);
            q_misalign <= Disable;
        end else begin
            q_valid    <= n_valid;
            q_aluop    <= n_aluop;
            q_wreg     <= n_wreg;
            q_waddr    <= n_waddr;
            q_alurslt  <= n_alurslt;
            q_memop    <= n_memop;
            q_memsize  <= n_memsize;
            q_sdata    <= n_sdata;
            q_misalign <= n_misalign;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready, stall hold, flush-to-bubble and bypass/hazard tap.
// Define EX_MEM_SKID_EN for a one-entry skid buffer with registered ex_ready_o.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF,
    parameter int unsigned ALUOP_W = ALUOP_W_DEF
) (
    input  logic            dclk,
    input  logic            rst,
    ex_mem_pipe_if.slave    bus
);

    logic               consume;
    logic               main_free;
    logic               accept;
    logic               main_load;
    logic               main_clear;

    logic [ALUOP_W-1:0] d_aluop;
    logic               d_wreg;
    logic [RADDR_W-1:0] d_waddr;
    logic [XLEN-1:0]    d_alurslt;
    logic [1:0]         d_memop;
    logic [1:0]         d_memsize;
    logic [XLEN-1:0]    d_sdata;
    logic               d_misalign;

    assign consume   = bus.mem_valid_o & bus.mem_ready_i;
    assign main_free = ~bus.mem_valid_o | bus.mem_ready_i;

`ifdef EX_MEM_SKID_EN
    logic               s_valid;
    logic [ALUOP_W-1:0] s_aluop;
    logic               s_wreg;
    logic [RADDR_W-1:0] s_waddr;
    logic [XLEN-1:0]    s_alurslt;
    logic [1:0]         s_memop;
    logic [1:0]         s_memsize;
    logic [XLEN-1:0]    s_sdata;
    logic               s_misalign;
    logic               skid_load;
    logic               skid_clear;

    // Ready depends only on skid occupancy, so it is a flop output with no path from mem_ready_i.
    assign bus.ex_ready_o = ~s_valid;
    assign accept         = bus.ex_valid_i & ~s_valid;
    assign main_load      = ~bus.flush_i & main_free & (s_valid | accept);
    assign main_clear     = bus.flush_i | (consume & ~s_valid & ~accept);
    assign skid_load      = ~bus.flush_i & accept & ~main_free;
    assign skid_clear     = bus.flush_i | (s_valid & main_free);

    // A parked skid entry is older than anything on the input, so it drains first.
    assign d_aluop    = s_valid ? s_aluop    : bus.aluop_i;
    assign d_wreg     = s_valid ? s_wreg     : bus.wreg_i;
    assign d_waddr    = s_valid ? s_waddr    : bus.waddr_i;
    assign d_alurslt  = s_valid ? s_alurslt  : bus.alurslt_i;
    assign d_memop    = s_valid ? s_memop    : bus.memop_i;
    assign d_memsize  = s_valid ? s_memsize  : bus.memsize_i;
    assign d_sdata    = s_valid ? s_sdata    : bus.sdata_i;
    assign d_misalign = s_valid ? s_misalign : Disable;

    pipe_slot #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .ALUOP_W (ALUOP_W)
    ) u_skid (
        .dclk       (dclk),
        .rst        (rst),
        .load       (skid_load),
        .clear      (skid_clear),
        .d_aluop    (bus.aluop_i),
        .d_wreg     (bus.wreg_i),
        .d_waddr    (bus.waddr_i),
        .d_alurslt  (bus.alurslt_i),
        .d_memop    (bus.memop_i),
        .d_memsize  (bus.memsize_i),
        .d_sdata    (bus.sdata_i),
        .d_misalign (Disable),
        .q_valid    (s_valid),
        .q_aluop    (s_aluop),
        .q_wreg     (s_wreg),
        .q_waddr    (s_waddr),
        .q_alurslt  (s_alurslt),
        .q_memop    (s_memop),
        .q_memsize  (s_memsize),
        .q_sdata    (s_sdata),
        .q_misalign (s_misalign)
    );
`else
    // Without a skid, ready passes straight through from the MEM side.
    assign bus.ex_ready_o = main_free;
    assign accept         = bus.ex_valid_i & main_free;
    assign main_load      = ~bus.flush_i & accept;
    assign main_clear     = bus.flush_i | (consume & ~accept);

    assign d_aluop    = bus.aluop_i;
    assign d_wreg     = bus.wreg_i;
    assign d_waddr    = bus.waddr_i;
    assign d_alurslt  = bus.alurslt_i;
    assign d_memop    = bus.memop_i;
    assign d_memsize  = bus.memsize_i;
    assign d_sdata    = bus.sdata_i;
    assign d_misalign = Disable;
`endif

    pipe_slot #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .ALUOP_W (ALUOP_W)
    ) u_main (
        .dclk       (dclk),
        .rst        (rst),
        .load       (main_load),
        .clear      (main_clear),
        .d_aluop    (d_aluop),
        .d_wreg     (d_wreg),
        .d_waddr    (d_waddr),
        .d_alurslt  (d_alurslt),
        .d_memop    (d_memop),
        .d_memsize  (d_memsize),
        .d_sdata    (d_sdata),
        .d_misalign (d_misalign),
        .q_valid    (bus.mem_valid_o),
        .q_aluop    (bus.aluop_o),
        .q_wreg     (bus.wreg_o),
        .q_waddr    (bus.waddr_o),
        .q_alurslt  (bus.alurslt_o),
        .q_memop    (bus.memop_o),
        .q_memsize  (bus.memsize_o),
        .q_sdata    (bus.sdata_o),
        .q_misalign (bus.misalign_o)
    );

    // Bypass tap: ALU results can be forwarded, loads must stall the consumer instead.
    assign bus.fwd_en_o      = bus.mem_valid_o & bus.wreg_o & ~is_load(bus.memop_o);
    assign bus.load_hazard_o = bus.mem_valid_o & bus.wreg_o & is_load(bus.memop_o);

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX→MEM pipeline register; next generation of the plain EX/MEM latch.
- Adds a valid/ready handshake, stall hold, flush-to-bubble, memory-op fields, misalignment detection and a forwarding/load-hazard tap for the EX-stage bypass network.
- Sits between the ALU/EX stage and the load-store/MEM stage of the RISC-V core.

Parameters:
- XLEN, 32, datapath width (ALU result, store data)
- RADDR_W, 5, register-file address width
- ALUOP_W, 8, ALU opcode width (matches shared AluOpBus)

Ports:
- dclk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ex_valid_i  in  1  EX presents a valid instruction
- ex_ready_o  out  1  stage can accept
- aluop_i  in  ALUOP_W  ALU opcode
- wreg_i  in  1  writes the register file
- waddr_i  in  RADDR_W  destination register
- alurslt_i  in  XLEN  ALU result / effective address
- memop_i  in  2  MEM_NONE=0, MEM_LOAD=1, MEM_STORE=2
- memsize_i  in  2  0=byte, 1=half, 2=word
- sdata_i  in  XLEN  store data
- flush_i  in  1  kill stage contents (branch/exception)
- mem_valid_o  out  1  MEM holds a valid instruction
- mem_ready_i  in  1  MEM consumes this cycle
- aluop_o, wreg_o, waddr_o, alurslt_o, memop_o, memsize_o, sdata_o  out  as inputs  registered copies
- misalign_o  out  1  registered misaligned-access flag
- fwd_en_o  out  1  forwarding-eligible result present
- load_hazard_o  out  1  pending load targets waddr_o

Behaviour:
- Reset (async, immediate):
  - mem_valid_o=0, aluop_o=ALU_NOP_OP, wreg_o=0, waddr_o=NopRegAddr(0)
  - alurslt_o=0, memop_o=MEM_NONE, memsize_o=0, sdata_o=0, misalign_o=0
  - skid empty (if built)
- Ready (no skid): ex_ready_o = ~mem_valid_o | mem_ready_i (combinational).
- Capture when ex_valid_i & ex_ready_o; latency 1 cycle to the MEM outputs.
- Hold: mem_valid_o & ~mem_ready_i keeps every output stable.
- Drain without new input: mem_valid_o→0; payload set to NOP values (wreg_o=0, memop_o=MEM_NONE).
- Flush: flush_i has priority over capture and hold.
  - Next edge: mem_valid_o=0, payload reset to NOP values.
  - The input presented that cycle is dropped.
- x0 write suppression: wreg_o captured as wreg_i & (waddr_i != 0).
- misalign_o computed at capture, only when memop_i != MEM_NONE:
  - half: alurslt_i[0] != 0
  - word: alurslt_i[1:0] != 0
  - byte: never misaligned
- fwd_en_o = mem_valid_o & wreg_o & (memop_o != MEM_LOAD).
- load_hazard_o = mem_valid_o & wreg_o & (memop_o == MEM_LOAD).
- Simultaneous consume and capture in the same cycle: new entry replaces old, no bubble.

Optional Feature:
- Macro: EX_MEM_SKID_EN.
- Defined:
  - One-entry skid buffer.
  - ex_ready_o is registered: ex_ready_o = ~skid_valid.
  - Input accepted while output stalled goes to skid.
  - On consume, skid moves to output next edge.
  - Order preserved; flush clears output and skid.
  - Full throughput when mem_ready_i=1.
- Undefined: combinational ready as above; no skid storage.

Decomposition:
- Shared package/macro header: AluOpBus, ALU_NOP_OP, NopRegAddr, ZeroWord, Enable/Disable, MEM_NONE/LOAD/STORE, MEM_SIZE_B/H/W codes.
- Sub-module pipe_slot holds one payload entry with load/clear controls.
  - Instantiated once for the main register, twice when EX_MEM_SKID_EN is defined.
  - Misalign logic lives in pipe_slot.

Test Plan:
- Reset mid-stall: valid word store held, assert rst → all outputs at NOP values immediately, mem_valid_o=0.
- Back-to-back flow: 4 ALU ops with mem_ready_i=1 → outputs appear 1 cycle after each; no bubbles; alurslt_o sequence matches.
- Stall: mem_ready_i=0 for 3 cycles with ex_valid_i=1 → outputs frozen; ex_ready_o=0 (no skid) or 1 for one cycle then 0 (skid); no loss or duplication.
- Flush vs capture: flush_i=1 while ex_valid_i=1, waddr=7 → next cycle mem_valid_o=0, wreg_o=0; the waddr=7 instruction is never seen.
- Misalign/x0: load half at 0x1001 → misalign_o=1; word store at 0x1004 → 0; wreg_i=1, waddr_i=0 → wreg_o=0, fwd_en_o=0.
- Hazard tap: load to x5 captured → load_hazard_o=1, fwd_en_o=0; ALU op to x5 → fwd_en_o=1, load_hazard_o=0.
